// File: rtl/graph_memory_responder_if.sv
// graph_memory_responder_if: read bus between graph requesters and the memory responder
//   mem_addr        requester -> responder  byte address of the read
//   mem_read_enable requester -> responder  read request, level
//   mem_data        responder -> requester  read data, valid while mem_read_ready=1
//   mem_read_ready  responder -> requester  one-cycle response strobe
`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 16
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 16
`endif
interface graph_memory_responder_if #(
   parameter int MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
   parameter int MDATA_WIDTH = `DEFAULT_MDATA_WIDTH
);
   logic [MADDR_WIDTH-1:0] mem_addr;
   logic                   mem_read_enable;
   logic [MDATA_WIDTH-1:0] mem_data;
   logic                   mem_read_ready;
   modport master (output mem_addr, mem_read_enable, input mem_data, mem_read_ready);
   modport slave (input mem_addr, mem_read_enable, output mem_data, mem_read_ready);
endinterface

// File: rtl/graph_memory_responder.sv
// graph_memory_responder: adjacency-matrix word store answering reads after a fixed latency
//   clock, reset (async active-low)
//   bus          slave side of the read bus (addr/enable in, data/ready out)
//   load_*       side port writing one word per cycle, usable in any state
//   busy         high whenever a read is in flight
//   addr_error   sticky flag for out-of-range or misaligned reads
//   read_count   completed reads, wrapping
`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 16
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 16
`endif
module graph_memory_responder #(
   parameter int                     MADDR_WIDTH  = `DEFAULT_MADDR_WIDTH,
   parameter int                     MDATA_WIDTH  = `DEFAULT_MDATA_WIDTH,
   parameter int                     WORD_BYTES   = MADDR_WIDTH / 8,
   parameter int                     DEPTH        = 1024,
   parameter logic [MADDR_WIDTH-1:0] BASE_ADDRESS = '0,
   parameter int                     READ_LATENCY = 2
) (
   input  logic                       clock,
   input  logic                       reset,
   graph_memory_responder_if.slave    bus,
   input  logic                       load_enable,
   input  logic [$clog2(DEPTH)-1:0]   load_index,
   input  logic [MDATA_WIDTH-1:0]     load_data,
   output logic                       busy,
   output logic                       addr_error,
   output logic [15:0]                read_count
);
   localparam int IW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, WAIT, RESPOND, RECOVER} state_t;
   state_t state, state_next;
   logic [MDATA_WIDTH-1:0] mem [DEPTH];
   logic [MDATA_WIDTH-1:0] resp;
   logic [3:0] cnt;
   logic [MADDR_WIDTH-1:0] off, idx;
   logic below, beyond, misaligned, start;
   assign off = bus.mem_addr - BASE_ADDRESS;
   assign idx = off / MADDR_WIDTH'(WORD_BYTES);
   assign below = bus.mem_addr < BASE_ADDRESS;
   assign beyond = 32'(idx) >= DEPTH;
   assign misaligned = (off % MADDR_WIDTH'(WORD_BYTES)) != '0;
   // an X/Z enable is treated as no request
   assign start = state == IDLE && bus.mem_read_enable === 1'b1;
   always_ff @(posedge clock or negedge reset)
      if (!reset) state <= IDLE;
      else state <= state_next;
   always_comb begin
      state_next = state == IDLE    ? (start ? WAIT : IDLE) :
                   state == WAIT    ? (cnt == '0 ? RESPOND : WAIT) :
                   state == RESPOND ? RECOVER : IDLE;
      bus.mem_read_ready = state == RESPOND;
      bus.mem_data = state == RESPOND ? resp : '0;
      busy = state != IDLE;
   end
   // the word is captured at accept, so later loads never reach this response
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
         resp <= '0;
         addr_error <= 1'b0;
         read_count <= '0;
      end else begin
         if (start) begin
            cnt <= 4'(READ_LATENCY - 1);
            resp <= below || beyond ? '0 : mem[idx[IW-1:0]];
            addr_error <= addr_error | below | beyond | misaligned;
         end else if (state == WAIT && cnt != '0) cnt <= cnt - 4'd1;
         if (state == RESPOND) read_count <= read_count + 16'd1;
      end
   end
   // storage survives reset
   always_ff @(posedge clock)
      if (load_enable && 32'(load_index) < DEPTH) mem[load_index] <= load_data;
endmodule

// File: tb/tb_graph_memory_responder.sv
// tb_graph_memory_responder: scoreboard bench for graph_memory_responder
module tb_graph_memory_responder;
   localparam int AW = 16, DW = 16, WB = 2, DEPTH = 1024, LAT = 2;
   localparam logic [AW-1:0] BASE = 16'h0100;
   logic clock = 0, reset = 0, load_enable = 0;
   logic [9:0] load_index = '0;
   logic [DW-1:0] load_data = '0;
   logic busy, addr_error;
   logic [15:0] read_count;
   int checks = 0, failures = 0, cyc = 0, pulses = 0, last_cyc = 0, t0 = 0;
   logic prev_ready = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] e;
   logic [15:0] exp_count = 0;

   graph_memory_responder_if #(.MADDR_WIDTH(AW), .MDATA_WIDTH(DW)) bus ();
   graph_memory_responder #(
      .MADDR_WIDTH(AW), .MDATA_WIDTH(DW), .WORD_BYTES(WB), .DEPTH(DEPTH),
      .BASE_ADDRESS(BASE), .READ_LATENCY(LAT)
   ) dut (
      .clock(clock), .reset(reset), .bus(bus), .load_enable(load_enable),
      .load_index(load_index), .load_data(load_data), .busy(busy),
      .addr_error(addr_error), .read_count(read_count)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      checks++;
      if (bus.mem_read_ready !== 1'b1 && bus.mem_data !== '0) begin
         failures++;
         $display("FAIL idle_data got=%h want=0", bus.mem_data);
      end
      if (bus.mem_read_ready === 1'b1) begin
         pulses++;
         last_cyc = cyc;
         checks++;
         if (prev_ready) begin
            failures++;
            $display("FAIL ready_width ready high two cycles in a row at cyc=%0d", cyc);
         end
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_ready got data=%h want no pulse", bus.mem_data);
         end else begin
            e = exp_q.pop_front();
            if (bus.mem_data !== e) begin
               failures++;
               $display("FAIL read_data got=%h want=%h", bus.mem_data, e);
            end
         end
      end
      prev_ready = bus.mem_read_ready === 1'b1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic load_word(input logic [9:0] i, input logic [DW-1:0] d);
      load_enable = 1; load_index = i; load_data = d;
      step();
      load_enable = 0;
   endtask

   task automatic reset_dut();
      reset = 0;
      step(); step();
      reset = 1;
      exp_count = 0;
      exp_q.delete();
   endtask

   task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] want,
                          input logic ld = 0, input logic [9:0] li = '0,
                          input logic [DW-1:0] ld_d = '0);
      int p0;
      exp_q.push_back(want);
      exp_count++;
      p0 = pulses;
      bus.mem_addr = addr; bus.mem_read_enable = 1;
      load_enable = ld; load_index = li; load_data = ld_d;
      step();
      bus.mem_read_enable = 0; load_enable = 0;
      t0 = cyc;
      for (int k = 0; k < 20 && pulses == p0; k++) step();
      checks++;
      if (pulses != p0 + 1) begin
         failures++;
         $display("FAIL read_timeout addr=%h pulses=%0d want=1", addr, pulses - p0);
      end else begin
         checks++;
         if (last_cyc - t0 != LAT) begin
            failures++;
            $display("FAIL latency addr=%h got=%0d want=%0d", addr, last_cyc - t0, LAT);
         end
      end
      for (int k = 0; k < 10 && busy; k++) step();
      checks++;
      if (read_count !== exp_count) begin
         failures++;
         $display("FAIL read_count got=%h want=%h", read_count, exp_count);
      end
   endtask

   task automatic test_reset();
      bus.mem_addr = '0; bus.mem_read_enable = 0;
      step(); step();
      checks++;
      if ({busy, addr_error, read_count, bus.mem_read_ready, bus.mem_data} !== '0) begin
         failures++;
         $display("FAIL reset_state got busy=%b err=%b cnt=%h rdy=%b data=%h want all 0",
                  busy, addr_error, read_count, bus.mem_read_ready, bus.mem_data);
      end
      reset = 1;
      step();
   endtask

   task automatic test_single_read();
      load_word(3, 16'h0007);
      do_read(BASE + AW'(3 * WB), 16'h0007);
   endtask

   task automatic test_back_to_back();
      int p0;
      load_word(0, 16'h0011); load_word(1, 16'h0022); load_word(2, 16'h0033);
      exp_q.push_back(16'h0011); exp_q.push_back(16'h0022); exp_q.push_back(16'h0033);
      exp_count += 3;
      p0 = pulses;
      bus.mem_read_enable = 1;
      for (int i = 0; i < 3; i++) begin
         bus.mem_addr = BASE + AW'(i * WB);
         for (int k = 0; k < 10 && !busy; k++) step();
         if (i == 2) bus.mem_read_enable = 0;
         for (int k = 0; k < 12 && busy; k++) step();
      end
      checks++;
      if (pulses != p0 + 3) begin
         failures++;
         $display("FAIL held_enable_pulses got=%0d want=3", pulses - p0);
      end
      checks++;
      if (read_count !== exp_count) begin
         failures++;
         $display("FAIL held_enable_count got=%h want=%h", read_count, exp_count);
      end
   endtask

   task automatic test_addr_error();
      do_read(BASE + AW'(DEPTH * WB), 16'h0000);
      checks++;
      if (addr_error !== 1'b1) begin failures++; $display("FAIL beyond_err got=%b want=1", addr_error); end
      do_read(BASE + AW'(3 * WB), 16'h0007);
      checks++;
      if (addr_error !== 1'b1) begin failures++; $display("FAIL sticky_err got=%b want=1", addr_error); end
      reset_dut();
      checks++;
      if (addr_error !== 1'b0) begin failures++; $display("FAIL err_cleared got=%b want=0", addr_error); end
      do_read(BASE - AW'(2), 16'h0000);
      checks++;
      if (addr_error !== 1'b1) begin failures++; $display("FAIL below_err got=%b want=1", addr_error); end
      reset_dut();
      do_read(BASE + AW'(3 * WB + 1), 16'h0007);
      checks++;
      if (addr_error !== 1'b1) begin failures++; $display("FAIL misalign_err got=%b want=1", addr_error); end
      reset_dut();
      do_read(BASE + AW'(3 * WB), 16'h0007);
      checks++;
      if (addr_error !== 1'b0) begin failures++; $display("FAIL good_read_err got=%b want=0", addr_error); end
   endtask

   task automatic test_load_collision();
      load_word(5, 16'h00AA);
      do_read(BASE + AW'(5 * WB), 16'h00AA, 1'b1, 10'd5, 16'h00BB);
      do_read(BASE + AW'(5 * WB), 16'h00BB);
   endtask

   task automatic test_reset_mid_request();
      int p0;
      p0 = pulses;
      bus.mem_addr = BASE + AW'(3 * WB); bus.mem_read_enable = 1;
      step();
      bus.mem_read_enable = 0;
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL wait_busy got=%b want=1", busy); end
      reset = 0;
      #1;
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL async_reset_busy got=%b want=0", busy); end
      step(); step();
      reset = 1;
      repeat (6) step();
      checks++;
      if (pulses != p0) begin failures++; $display("FAIL aborted_pulse got=%0d want=0", pulses - p0); end
      checks++;
      if (read_count !== 16'h0000) begin failures++; $display("FAIL aborted_count got=%h want=0", read_count); end
      exp_count = 0;
      do_read(BASE + AW'(3 * WB), 16'h0007);
   endtask

   task automatic test_count_wrap();
      force dut.read_count = 16'hFFFF;
      step();
      release dut.read_count;
      exp_count = 16'hFFFF;
      checks++;
      if (read_count !== 16'hFFFF) begin failures++; $display("FAIL preset_count got=%h want=ffff", read_count); end
      do_read(BASE + AW'(1 * WB), 16'h0022);
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_back_to_back();
      test_addr_error();
      test_load_collision();
      test_reset_mid_request();
      test_count_wrap();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL leftover_expected got=%0d want=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
